// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: adds two WIDTH-bit operands LSB-first through one
// full-add stage (two half-adder cells plus a carry flop), one bit per enabled cycle.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ss;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Full add of the current LSBs built from two half-adder cells.
  logic ha0_s, ha0_c, ha1_c;
  logic bit_s, bit_c;

  assign ha0_s = sa[0] ^ sb[0];
  assign ha0_c = sa[0] & sb[0];
  assign bit_s = ha0_s ^ carry;
  assign ha1_c = ha0_s & carry;
  assign bit_c = ha0_c | ha1_c;

  // Handshake: start is only looked at in IDLE on an enabled edge; busy marks
  // RUN and done is a one-state strobe, so the two are never high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      ss    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
            sa    <= a;
            sb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          ss    <= {bit_s, ss[WIDTH-1:1]};
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Result is published only here, so sum/cout never show partials.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {bit_s, ss[WIDTH-1:1]};
            cout  <= bit_c;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
